// File: rtl/wgt_pkg.sv
// Shared definitions for the weight loader: FSM encoding, kernel-size codes,
// lane counts per mode and line counts per mode.
package wgt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] KSIZE_3 = 3'd3;
    localparam logic [2:0] KSIZE_5 = 3'd5;

    localparam logic [3:0] VALID_3 = 4'd3;
    localparam logic [3:0] VALID_8 = 4'd8;

    localparam int LINES_3 = 24;
    localparam int LINES_5 = 25;

    // Only 3x3 and 5x5 kernels have a line geometry.
    function automatic logic ksize_legal(input logic [2:0] k);
        return (k == KSIZE_3) || (k == KSIZE_5);
    endfunction

endpackage

// File: rtl/wgt_line_packer.sv
// Lane register for one weight line. Each lane captures a streamed word when
// addressed; clear zeroes every lane so a new line starts clean. Lanes at or
// above lane_cnt are forced to zero on the output so padding never carries data.
// The output reflects the line as it stands after this cycle's clear/push,
// which lets the caller register a complete line on the same edge that
// accepts its last word.
module wgt_line_packer
    import wgt_pkg::*;
#(
    parameter int DATA_WID = 16,
    parameter int SIZE     = 8,
    parameter int IDX_WID  = $clog2(SIZE)
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_WID-1:0]      word,
    input  logic [IDX_WID-1:0]       lane_idx,
    input  logic [3:0]               lane_cnt,
    output logic [DATA_WID*SIZE-1:0] line
);

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        localparam logic [IDX_WID-1:0] LANE_IDX = IDX_WID'(gi);
        localparam logic [3:0]         LANE_NUM = 4'(gi);

        logic [DATA_WID-1:0] r_lane;
        logic [DATA_WID-1:0] w_lane_next;
        logic                w_keep;

        // Next lane value: a push to this lane wins over a clear.
        always_comb begin
            w_lane_next = r_lane;
            if (clear) begin
                w_lane_next = '0;
            end
            if (push && (lane_idx == LANE_IDX)) begin
                w_lane_next = word;
            end
        end

        // Lane storage.
        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                r_lane <= '0;
            end else begin
                r_lane <= w_lane_next;
            end
        end

        assign w_keep = (LANE_NUM < lane_cnt);
        assign line[gi*DATA_WID +: DATA_WID] = w_keep ? w_lane_next : '0;
    end

endmodule

// File: rtl/wgt_loader.sv
// Weight loader: accepts a 16-bit weight stream over valid/ready, packs it
// into lines (3 words for 3x3 kernels, 8 words for 5x5) and writes each line
// to the weight buffer. i2c_ready frames the transfer toward the buffer.
module wgt_loader
    import wgt_pkg::*;
#(
    parameter int DATA_WID = 16,
    parameter int SIZE     = 8,
    parameter int ADDR_WID = 5
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               ksize,
    input  logic [DATA_WID-1:0]      s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     i2c_ready,
    output logic                     wgt_wr_en,
    output logic [ADDR_WID-1:0]      wgt_wr_addr,
    output logic [DATA_WID*SIZE-1:0] weights_in,
    output logic [3:0]               valid_num,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int IDX_WID = $clog2(SIZE);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_mode5;
    logic [IDX_WID-1:0]        r_word_cnt;
    logic [ADDR_WID-1:0]       r_line_cnt;

    logic                      w_start_ok;
    logic                      w_start_bad;
    logic [3:0]                w_lane_cnt;
    logic                      w_last_word;
    logic                      w_last_line;
    logic                      w_clear;
    logic                      w_push;
    logic                      w_line_full;
    logic [DATA_WID*SIZE-1:0]  w_line;

    assign w_start_ok  = (r_state == ST_IDLE) && start && ksize_legal(ksize);
    assign w_start_bad = (r_state == ST_IDLE) && start && !ksize_legal(ksize);
    assign w_lane_cnt  = r_mode5 ? VALID_8 : VALID_3;
    assign w_last_word = ((4'(r_word_cnt) + 4'd1) == w_lane_cnt);
    assign w_last_line = r_mode5 ? (r_line_cnt == ADDR_WID'(LINES_5 - 1))
                                 : (r_line_cnt == ADDR_WID'(LINES_3 - 1));

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the lane-register controls and s_ready.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_push       = 1'b0;
        w_line_full  = 1'b0;
        s_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_push = 1'b1;
                    if (w_last_word) begin
                        w_line_full  = 1'b1;
                        w_state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                w_clear = 1'b1;
                if (w_last_line) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Mode latch plus word and line counters.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_mode5    <= 1'b0;
            r_word_cnt <= '0;
            r_line_cnt <= '0;
        end else if (w_start_ok) begin
            r_mode5    <= (ksize == KSIZE_5);
            r_word_cnt <= '0;
            r_line_cnt <= '0;
        end else if (w_push) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end else if (r_state == ST_WRITE) begin
            r_word_cnt <= '0;
            if (!w_last_line) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
        end
    end

    wgt_line_packer #(
        .DATA_WID (DATA_WID),
        .SIZE     (SIZE)
    ) u_packer (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .push     (w_push),
        .word     (s_data),
        .lane_idx (r_word_cnt),
        .lane_cnt (w_lane_cnt),
        .line     (w_line)
    );

    // Registered status/framing outputs, derived from the state being entered.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            i2c_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wgt_wr_en <= 1'b0;
        end else begin
            i2c_ready <= (w_state_next == ST_IDLE) || (w_state_next == ST_DONE);
            busy      <= (w_state_next != ST_IDLE);
            done      <= (w_state_next == ST_DONE);
            err       <= w_start_bad;
            wgt_wr_en <= (w_state_next == ST_WRITE);
        end
    end

    // Write payload: captured on the edge that accepts a line's last word and
    // held until the next line completes.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wgt_wr_addr <= '0;
            weights_in  <= '0;
            valid_num   <= '0;
        end else if (w_line_full) begin
            wgt_wr_addr <= r_line_cnt;
            weights_in  <= w_line;
            valid_num   <= w_lane_cnt;
        end
    end

endmodule
